// File: rtl/reset_sequencer_pkg.sv
// Shared types and helpers for the decoder-domain reset sequencer.
// Holds the FSM state encoding and the counter width helper.
package reset_sequencer_pkg;

    typedef enum logic [1:0] {
        StAssert  = 2'd0,
        StRelease = 2'd1,
        StRun     = 2'd2
    } rst_state_e;

    // The same counter times both the stretch and the stagger phases.
    function automatic int unsigned cnt_width(input int unsigned stretch,
                                              input int unsigned stagger);
        return $clog2(((stretch > stagger) ? stretch : stagger) + 1);
    endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// Reset sources, requests and sequenced outputs of the reset sequencer.
// The master drives the requests; the slave (sequencer) drives the results.
interface reset_sequencer_if #(
    parameter int unsigned NUM_SRC = 2,
    parameter int unsigned NUM_OUT = 3
);

    logic [NUM_SRC-1:0] src_rst_n;
    logic               sw_rst_req;
    logic               cause_clr;
    logic [NUM_OUT-1:0] rst_out_n;
    logic               hard_rst_n;
    logic               busy;
    logic [NUM_SRC:0]   rst_cause;

    modport master (
        output src_rst_n, sw_rst_req, cause_clr,
        input  rst_out_n, hard_rst_n, busy, rst_cause
    );

    modport slave (
        input  src_rst_n, sw_rst_req, cause_clr,
        output rst_out_n, hard_rst_n, busy, rst_cause
    );

endinterface

// File: rtl/reset_sync_chain.sv
// Reset synchronizer: asynchronously cleared flop chain shifting in d on clk.
module reset_sync_chain #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic arst_n,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d};
        end
    end

    assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Decoder-domain reset sequencer: stretches and staggers reset release across
// NUM_OUT outputs and keeps a sticky record of what caused the last reset.
module reset_sequencer
    import reset_sequencer_pkg::*;
#(
    parameter int unsigned NUM_SRC     = 2,
    parameter int unsigned NUM_OUT     = 3,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned STRETCH     = 16,
    parameter int unsigned STAGGER     = 4
) (
    input  logic              clk,
    input  logic              async_rst,
    reset_sequencer_if.slave  bus
);

    localparam int unsigned CntW = cnt_width(STRETCH, STAGGER);
    localparam int unsigned IdxW = $clog2(NUM_OUT + 1);

    logic               a_ok;
    logic [NUM_SRC-1:0] s_ok;
    logic               hold;
    logic [NUM_SRC:0]   cause_set;

    rst_state_e         state_q;
    logic [CntW-1:0]    cnt_q;
    logic [IdxW-1:0]    idx_q;
    logic [NUM_OUT-1:0] rst_out_q;
    logic               busy_q;
    logic               hard_q;
    logic [NUM_SRC:0]   cause_q;

    reset_sync_chain #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_a_sync (
        .clk    (clk),
        .arst_n (async_rst),
        .d      (1'b1),
        .q      (a_ok)
    );

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src_sync
        reset_sync_chain #(
            .SYNC_STAGES (SYNC_STAGES)
        ) u_src_sync (
            .clk    (clk),
            .arst_n (async_rst),
            .d      (bus.src_rst_n[i]),
            .q      (s_ok[i])
        );
    end

    assign hold = !a_ok || !(&s_ok) || bus.sw_rst_req;

    always_ff @(posedge clk or negedge async_rst) begin
        if (!async_rst) begin
            state_q   <= StAssert;
            cnt_q     <= '0;
            idx_q     <= '0;
            rst_out_q <= '0;
            busy_q    <= 1'b1;
        end else if (hold) begin
            // Any reset request collapses every output at once; no partial release.
            state_q   <= StAssert;
            cnt_q     <= '0;
            idx_q     <= '0;
            rst_out_q <= '0;
            busy_q    <= 1'b1;
        end else begin
            unique case (state_q)
                StAssert: begin
                    if (cnt_q == CntW'(STRETCH - 1)) begin
                        rst_out_q[0] <= 1'b1;
                        cnt_q        <= '0;
                        idx_q        <= IdxW'(1);
                        if (NUM_OUT == 1) begin
                            state_q <= StRun;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= StRelease;
                        end
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StRelease: begin
                    if (cnt_q == CntW'(STAGGER - 1)) begin
                        rst_out_q <= rst_out_q | (NUM_OUT'(1) << idx_q);
                        cnt_q     <= '0;
                        idx_q     <= idx_q + IdxW'(1);
                        if (idx_q == IdxW'(NUM_OUT - 1)) begin
                            state_q <= StRun;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StRun: begin
                    rst_out_q <= '1;
                    busy_q    <= 1'b0;
                end
                default: begin
                    state_q   <= StAssert;
                    rst_out_q <= '0;
                    busy_q    <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge async_rst) begin
        if (!async_rst) begin
            hard_q <= 1'b0;
        end else begin
            hard_q <= a_ok;
        end
    end

    // Source causes only count once the global reset is gone; set beats clear.
    assign cause_set = {bus.sw_rst_req, ~s_ok & {NUM_SRC{a_ok}}};

    always_ff @(posedge clk or negedge async_rst) begin
        if (!async_rst) begin
            cause_q <= '0;
        end else begin
            cause_q <= (bus.cause_clr ? '0 : cause_q) | cause_set;
        end
    end

    assign bus.rst_out_n  = rst_out_q;
    assign bus.busy       = busy_q;
    assign bus.hard_rst_n = hard_q;
    assign bus.rst_cause  = cause_q;

endmodule
